wave_gen_nco: RTL and testbench

Parametrised, clocked successor to the combinational sawtooth lookup. Contains its own phase accumulator with a programmable step, so the team gets a free-running NCO instead of an externally driven address. Generates sawtooth, triangle or square waveforms with a duty/peak position selectable in 10% steps. Configuration is shadowed and applied only at period wrap, so changes are glitch-free. Feeds the DSP datapath as a sample source with a valid strobe.

---
 rtl/wave_pkg.sv | 19 +
 rtl/wave_ramp_scale.sv | 50 +++++
 rtl/wave_gen_nco.sv | 183 ++++++++++++++++++
 tb/tb_wave_gen_nco.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wave_pkg.sv
// Shared types and constants for the wave_gen_nco sample source.
// Waveform selector, duty resolution and the peak-position helper.
package wave_pkg;

    typedef enum logic [1:0] {
        SAW    = 2'd0,
        TRI    = 2'd1,
        SQUARE = 2'd2,
        RSVD   = 2'd3
    } wave_mode_e;

    localparam int unsigned DUTY_STEPS = 10;

    // Phase count at which the waveform switches segment, floor(N*sel/10).
    function automatic int unsigned calc_peak(input int unsigned sel, input int unsigned phase_w);
        return ((32'd1 << phase_w) * sel) / DUTY_STEPS;
    endfunction

endpackage

// File: rtl/wave_ramp_scale.sv
// Second pipeline stage of wave_gen_nco: registered num*MAX_VAL/den scaling
// with constant-level overrides and optional output inversion.
module wave_ramp_scale
    import wave_pkg::*;
#(
    parameter int                PHASE_W = 10,
    parameter int                DATA_W  = 24,
    parameter logic [DATA_W-1:0] MAX_VAL = 24'h1FFFFF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic [PHASE_W-1:0] num,
    input  logic [PHASE_W:0]   den,
    input  logic               zero,
    input  logic               full,
    input  logic               invert,
    output logic [DATA_W-1:0]  data
);

    localparam int PROD_W = PHASE_W + DATA_W;

    logic [PROD_W-1:0] prod;
    logic [DATA_W-1:0] quot;
    logic [DATA_W-1:0] val;
    logic [DATA_W-1:0] data_next;

    // Product is formed at full width so the floor divide never loses carries.
    assign prod = PROD_W'(num) * PROD_W'(MAX_VAL);
    assign quot = (den == '0) ? '0 : DATA_W'(prod / PROD_W'(den));

    always_comb begin
        val = quot;
        if (zero) begin
            val = '0;
        end else if (full) begin
            val = MAX_VAL;
        end
        data_next = invert ? (MAX_VAL - val) : val;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data <= '0;
        end else if (en) begin
            data <= data_next;
        end
    end

endmodule

// File: rtl/wave_gen_nco.sv
// Free-running NCO sample source: phase accumulator, wrap-shadowed config and a
// two-stage shape pipeline. Optional WAVE_INVERT_EN adds the i_invert port.
module wave_gen_nco
    import wave_pkg::*;
#(
    parameter int                PHASE_W = 10,
    parameter int                DATA_W  = 24,
    parameter logic [DATA_W-1:0] MAX_VAL = 24'h1FFFFF
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_en,
    input  logic [PHASE_W-1:0] i_step,
    input  logic               i_sync,
    input  logic [1:0]         i_mode,
    input  logic [3:0]         i_sel,
`ifdef WAVE_INVERT_EN
    input  logic               i_invert,
`endif
    output logic [DATA_W-1:0]  o_data,
    output logic               o_valid,
    output logic               o_wrap
);

    localparam logic [PHASE_W:0] FULL_SCALE = {1'b1, {PHASE_W{1'b0}}};

    logic [PHASE_W-1:0] phase_reg;
    logic               wrap_reg;
    logic [3:0]         sel_q;
    wave_mode_e         mode_q;
    logic               inv_q;
    logic               inv_in;

    logic [PHASE_W:0]   sum;
    logic               carry;
    logic               load_cfg;
    logic               adv;
    logic [3:0]         sel_clamped;

`ifdef WAVE_INVERT_EN
    assign inv_in = i_invert;
`else
    assign inv_in = 1'b0;
`endif

    assign sum         = {1'b0, phase_reg} + {1'b0, i_step};
    assign carry       = sum[PHASE_W];
    assign adv         = i_en | i_sync;
    assign load_cfg    = i_sync | (i_en & carry);
    assign sel_clamped = (i_sel > 4'(DUTY_STEPS)) ? 4'(DUTY_STEPS) : i_sel;

    // wrap_reg marks that phase_reg currently holds the first phase of a period.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            phase_reg <= '0;
            wrap_reg  <= 1'b0;
        end else if (i_sync) begin
            phase_reg <= '0;
            wrap_reg  <= 1'b1;
        end else if (i_en) begin
            phase_reg <= sum[PHASE_W-1:0];
            wrap_reg  <= carry;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sel_q  <= '0;
            mode_q <= SAW;
            inv_q  <= 1'b0;
        end else if (load_cfg) begin
            sel_q  <= sel_clamped;
            mode_q <= wave_mode_e'(i_mode);
            inv_q  <= inv_in;
        end
    end

    // Peak positions for every legal duty setting, resolved at elaboration.
    logic [PHASE_W:0] peak_lut [0:DUTY_STEPS];

    generate
        for (genvar gi = 0; gi <= DUTY_STEPS; gi++) begin : g_peak
            localparam int unsigned PEAK_VAL = calc_peak(gi, PHASE_W);
            assign peak_lut[gi] = (PHASE_W+1)'(PEAK_VAL);
        end
    endgenerate

    logic [PHASE_W:0]   peak;
    logic               rising;
    logic [PHASE_W-1:0] num_next;
    logic [PHASE_W:0]   den_next;
    logic               zero_next;
    logic               full_next;

    assign peak   = peak_lut[sel_q];
    assign rising = {1'b0, phase_reg} < peak;

    always_comb begin
        num_next  = phase_reg;
        den_next  = peak;
        zero_next = 1'b0;
        full_next = 1'b0;
        if (sel_q == '0) begin
            zero_next = 1'b1;
        end else begin
            case (mode_q)
                SAW: begin
                    zero_next = ~rising;
                end
                TRI: begin
                    if (!rising) begin
                        num_next = ~phase_reg;
                        den_next = FULL_SCALE - peak;
                    end
                end
                SQUARE: begin
                    full_next = rising;
                    zero_next = ~rising;
                end
                default: begin
                    zero_next = 1'b1;
                end
            endcase
        end
    end

    logic [PHASE_W-1:0] num_reg;
    logic [PHASE_W:0]   den_reg;
    logic               zero_reg;
    logic               full_reg;
    logic               inv_reg;
    logic               valid1_reg;
    logic               wrap1_reg;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            num_reg    <= '0;
            den_reg    <= '0;
            zero_reg   <= 1'b0;
            full_reg   <= 1'b0;
            inv_reg    <= 1'b0;
            valid1_reg <= 1'b0;
            wrap1_reg  <= 1'b0;
        end else begin
            valid1_reg <= adv;
            wrap1_reg  <= adv & wrap_reg;
            if (adv) begin
                num_reg  <= num_next;
                den_reg  <= den_next;
                zero_reg <= zero_next;
                full_reg <= full_next;
                inv_reg  <= inv_q;
            end
        end
    end

    wave_ramp_scale #(
        .PHASE_W (PHASE_W),
        .DATA_W  (DATA_W),
        .MAX_VAL (MAX_VAL)
    ) u_scale (
        .clk    (i_clk),
        .rst_n  (i_rst_n),
        .en     (valid1_reg),
        .num    (num_reg),
        .den    (den_reg),
        .zero   (zero_reg),
        .full   (full_reg),
        .invert (inv_reg),
        .data   (o_data)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_valid <= 1'b0;
            o_wrap  <= 1'b0;
        end else begin
            o_valid <= valid1_reg;
            o_wrap  <= wrap1_reg;
        end
    end

endmodule

// File: tb/tb_wave_gen_nco.sv
// Self-checking bench for wave_gen_nco: directed segments plus random stimulus
// against a period-level waveform model. Honors WAVE_INVERT_EN when defined.
module tb_wave_gen_nco;

    localparam int                PHASE_W = 10;
    localparam int                DATA_W  = 24;
    localparam logic [DATA_W-1:0] MAX_VAL = 24'h1FFFFF;
    localparam longint            N       = 1024;
    localparam longint            MAXL    = 64'h1FFFFF;

    logic               i_clk = 1'b0;
    logic               i_rst_n;
    logic               i_en;
    logic [PHASE_W-1:0] i_step;
    logic               i_sync;
    logic [1:0]         i_mode;
    logic [3:0]         i_sel;
`ifdef WAVE_INVERT_EN
    logic               i_invert;
`endif
    logic [DATA_W-1:0]  o_data;
    logic               o_valid;
    logic               o_wrap;

    always #5 i_clk = ~i_clk;

    wave_gen_nco #(
        .PHASE_W (PHASE_W),
        .DATA_W  (DATA_W),
        .MAX_VAL (MAX_VAL)
    ) dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_en    (i_en),
        .i_step  (i_step),
        .i_sync  (i_sync),
        .i_mode  (i_mode),
        .i_sel   (i_sel),
`ifdef WAVE_INVERT_EN
        .i_invert(i_invert),
`endif
        .o_data  (o_data),
        .o_valid (o_valid),
        .o_wrap  (o_wrap)
    );

    typedef struct {
        bit     valid;
        bit     wrap;
        longint data;
        int     phase;
        int     sel;
        int     mode;
        int     inv;
    } samp_t;

    samp_t  pipe[$];
    int     m_phase, m_sel, m_mode, m_inv;
    bit     m_first;
    longint last_data;
    int     n_checks = 0;
    int     n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int cur_inv();
`ifdef WAVE_INVERT_EN
        return int'(i_invert);
`else
        return 0;
`endif
    endfunction

    // Waveform value straight from the shape rules for phase p.
    function automatic longint shape(input int p, input int sel, input int mode, input int inv);
        longint peak, val;
        peak = (N * sel) / 10;
        val  = 0;
        if (sel != 0) begin
            case (mode)
                0: val = (p < peak) ? (p * MAXL) / peak : 0;
                1: begin
                    if (p < peak) val = (p * MAXL) / peak;
                    else          val = ((N - 1 - p) * MAXL) / (N - peak);
                end
                2: val = (p < peak) ? MAXL : 0;
                default: val = 0;
            endcase
        end
        if (inv != 0) val = MAXL - val;
        return val & ((64'd1 << DATA_W) - 1);
    endfunction

    // Hand-computed reference points for uninverted output.
    function automatic bit spot(input int mode, input int sel, input int p, output longint v);
        v = 0;
        if      (mode == 0 && sel == 5  && p == 256)  v = 64'h0FFFFF;
        else if (mode == 0 && sel == 5  && p == 511)  v = 64'h1FEFFF;
        else if (mode == 0 && sel == 5  && p == 512)  v = 0;
        else if (mode == 1 && sel == 5  && p == 511)  v = 64'h1FEFFF;
        else if (mode == 1 && sel == 5  && p == 512)  v = 64'h1FEFFF;
        else if (mode == 1 && sel == 5  && p == 1023) v = 0;
        else if (mode == 1 && sel == 5  && p == 0)    v = 0;
        else if (mode == 2 && sel == 3  && p == 306)  v = 64'h1FFFFF;
        else if (mode == 2 && sel == 3  && p == 307)  v = 0;
        else if (mode == 0 && sel == 10 && p == 1023) v = 64'h1FF7FF;
        else if (mode == 0 && sel == 2  && p == 203)  v = (203 * MAXL) / 204;
        else if (mode == 0 && sel == 2  && p == 204)  v = 0;
        else return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_reset();
        m_phase   = 0;
        m_sel     = 0;
        m_mode    = 0;
        m_inv     = 0;
        m_first   = 1'b0;
        last_data = 0;
        pipe.delete();
        pipe.push_back('{valid: 1'b0, wrap: 1'b0, data: 0, phase: 0, sel: 0, mode: 0, inv: 0});
    endtask

    task automatic model_load();
        m_sel  = (int'(i_sel) > 10) ? 10 : int'(i_sel);
        m_mode = int'(i_mode);
        m_inv  = cur_inv();
    endtask

    // One clock: queue the sample for the current phase, advance, compare.
    task automatic tick();
        samp_t  s, e;
        longint sum, sv;
        s.valid = i_en | i_sync;
        s.phase = m_phase;
        s.sel   = m_sel;
        s.mode  = m_mode;
        s.inv   = m_inv;
        s.data  = shape(m_phase, m_sel, m_mode, m_inv);
        s.wrap  = m_first & s.valid;
        pipe.push_back(s);
        @(posedge i_clk);
        if (i_sync) begin
            m_phase = 0;
            m_first = 1'b1;
            model_load();
        end else if (i_en) begin
            sum     = longint'(m_phase) + longint'(i_step);
            m_phase = int'(sum % N);
            m_first = (sum >= N);
            if (sum >= N) model_load();
        end
        #1;
        e = pipe.pop_front();
        if (e.valid) last_data = e.data;
        check("o_valid", 64'(o_valid), 64'(e.valid));
        check("o_wrap", 64'(o_wrap), 64'(e.wrap));
        check("o_data", 64'(o_data), last_data);
        if (e.valid && e.inv == 0 && spot(e.mode, e.sel, e.phase, sv))
            check("spot", 64'(o_data), sv);
        if (e.valid)
            $display("sample phase=%0d mode=%0d sel=%0d data=%06h wrap=%0b",
                     e.phase, e.mode, e.sel, o_data, o_wrap);
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic sync_cfg(input int mode, input int sel);
        i_mode = 2'(mode);
        i_sel  = 4'(sel);
        i_sync = 1'b1;
        tick();
        i_sync = 1'b0;
    endtask

    initial begin
        i_rst_n = 1'b0;
        i_en    = 1'b0;
        i_sync  = 1'b0;
        i_step  = '0;
        i_mode  = '0;
        i_sel   = '0;
`ifdef WAVE_INVERT_EN
        i_invert = 1'b0;
`endif
        repeat (2) @(posedge i_clk);
        #3;
        check("rst_data", 64'(o_data), 64'd0);
        check("rst_valid", 64'(o_valid), 64'd0);
        check("rst_wrap", 64'(o_wrap), 64'd0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        model_reset();

        // Sawtooth at 50 %, mid-period duty change takes effect only after wrap
        i_en   = 1'b1;
        i_step = 10'd1;
        sync_cfg(0, 5);
        run(1100);
        sync_cfg(0, 5);
        run(300);
        i_sel = 4'd2;
        run(1000);

        sync_cfg(1, 5);
        run(1030);
        sync_cfg(2, 3);
        run(1030);
        for (int m = 0; m < 4; m++) begin
            i_step = 10'd37;
            sync_cfg(m, 0);
            run(60);
        end

        // Out-of-range duty clamps to full scale
        i_step = 10'd1;
        sync_cfg(0, 12);
        run(1030);

        // Resync mid-period at phase 700 with a new configuration
        sync_cfg(1, 7);
        for (int k = 0; k < 2048 && m_phase != 700; k++) tick();
        check("reach700", 64'(m_phase), 64'd700);
        i_mode = 2'd2;
        i_sel  = 4'd4;
        i_sync = 1'b1;
        tick();
        i_sync = 1'b0;
        run(4);
        i_en = 1'b0;
        run(5);
        i_en = 1'b1;
        run(6);

        // Zero step keeps the output constant while valid stays high
        i_step = 10'd100;
        sync_cfg(1, 5);
        run(3);
        i_step = 10'd0;
        run(8);

        // Asynchronous reset between clock edges
        i_step = 10'd1;
        run(50);
        #2;
        i_rst_n = 1'b0;
        #1;
        check("arst_data", 64'(o_data), 64'd0);
        check("arst_valid", 64'(o_valid), 64'd0);
        check("arst_wrap", 64'(o_wrap), 64'd0);
        @(negedge i_clk);
`ifdef WAVE_INVERT_EN
        i_invert = 1'b1;
`endif
        i_rst_n = 1'b1;
        model_reset();
        run(4);
        sync_cfg(0, 5);
        run(20);

        // Randomized operation
        for (int k = 0; k < 2000; k++) begin
            i_en   = ($urandom_range(0, 9) < 8);
            i_sync = ($urandom_range(0, 99) == 0);
            i_step = ($urandom_range(0, 3) == 0) ? PHASE_W'($urandom) : PHASE_W'($urandom_range(1, 24));
            i_sel  = 4'($urandom);
            i_mode = 2'($urandom);
`ifdef WAVE_INVERT_EN
            i_invert = 1'($urandom);
`endif
            tick();
        end
        i_sync = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
